// File: rtl/dcache_controller_pkg.sv
// Shared configuration, derived widths and types for the direct-mapped,
// write-back data-cache controller.
`ifndef DCACHE_INDEX
`define DCACHE_INDEX 3
`endif
`ifndef DCACHE_SIZE
`define DCACHE_SIZE 8
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 12
`endif

package dcache_controller_pkg;

  localparam int DCACHE_INDEX      = `DCACHE_INDEX;
  localparam int DCACHE_SIZE       = `DCACHE_SIZE;
  localparam int DRAM_BLOCK_SIZE   = `DRAM_BLOCK_SIZE;
  localparam int DRAM_WORD_SIZE    = `DRAM_WORD_SIZE;
  localparam int DRAM_ADDRESS_SIZE = `DRAM_ADDRESS_SIZE;
  localparam int DCACHE_OFFSET     = $clog2(DRAM_BLOCK_SIZE);
  localparam int DCACHE_TAG        = DRAM_ADDRESS_SIZE - DCACHE_INDEX - DCACHE_OFFSET;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  typedef logic [DRAM_BLOCK_SIZE-1:0][DRAM_WORD_SIZE-1:0] line_t;

  // Replace one word of a cache line, leaving the rest untouched.
  function automatic line_t merge_word(input line_t line,
                                       input logic [DCACHE_OFFSET-1:0] offset,
                                       input logic [DRAM_WORD_SIZE-1:0] word);
    line_t result;
    result = line;
    result[offset] = word;
    return result;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_controller_tag_sram.sv
// Tag/valid/dirty store: combinational read, single registered write port.
module dcache_tag_sram
  import dcache_controller_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [DCACHE_INDEX-1:0] rd_index,
  output logic [DCACHE_TAG-1:0]   rd_tag,
  output logic                    rd_valid,
  output logic                    rd_dirty,
  input  logic                    wr_en,
  input  logic [DCACHE_INDEX-1:0] wr_index,
  input  logic [DCACHE_TAG-1:0]   wr_tag,
  input  logic                    wr_dirty
);

  logic [DCACHE_TAG-1:0]  tag_r [DCACHE_SIZE];
  logic [DCACHE_SIZE-1:0] valid_r;
  logic [DCACHE_SIZE-1:0] dirty_r;

  // Array update; every write leaves the entry valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
      dirty_r <= '0;
      for (int i = 0; i < DCACHE_SIZE; i++) begin
        tag_r[i] <= '0;
      end
    end else if (wr_en) begin
      tag_r[wr_index]   <= wr_tag;
      valid_r[wr_index] <= 1'b1;
      dirty_r[wr_index] <= wr_dirty;
    end
  end

  assign rd_tag   = tag_r[rd_index];
  assign rd_valid = valid_r[rd_index];
  assign rd_dirty = dirty_r[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data-cache controller: COMPARE/WRITEBACK/ALLOCATE
// FSM, same-cycle hits, blocking block fills and saturating statistics.
module dcache_controller
  import dcache_controller_pkg::*;
(
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic                                      cpu_req,
  input  logic                                      cpu_we,
  input  logic [DRAM_ADDRESS_SIZE-1:0]              cpu_addr,
  input  logic [DRAM_WORD_SIZE-1:0]                 cpu_wdata,
  output logic [DRAM_WORD_SIZE-1:0]                 cpu_rdata,
  output logic                                      cpu_ready,
  output logic                                      sram_we,
  output logic [DCACHE_INDEX-1:0]                   sram_index,
  output line_t                                     sram_wdata,
  input  line_t                                     sram_rdata,
  output logic                                      mem_req,
  output logic                                      mem_we,
  output logic [DRAM_ADDRESS_SIZE-DCACHE_OFFSET-1:0] mem_addr,
  output line_t                                     mem_wdata,
  input  line_t                                     mem_rdata,
  input  logic                                      mem_ready,
  output logic [31:0]                               hit_count,
  output logic [31:0]                               miss_count,
  output logic [31:0]                               wb_count
);

  state_t                                     state_r;
  logic                                       mem_req_r;
  logic                                       mem_we_r;
  logic [DRAM_ADDRESS_SIZE-DCACHE_OFFSET-1:0] mem_addr_r;
  logic                                       refill_r;
  logic [31:0]                                hit_cnt_r;
  logic [31:0]                                miss_cnt_r;
  logic [31:0]                                wb_cnt_r;

  logic [DCACHE_TAG-1:0]                      cpu_tag_s;
  logic [DCACHE_INDEX-1:0]                    cpu_index_s;
  logic [DCACHE_OFFSET-1:0]                   cpu_offset_s;
  logic [DRAM_ADDRESS_SIZE-DCACHE_OFFSET-1:0] cpu_block_s;
  logic [DCACHE_TAG-1:0]                      rd_tag_s;
  logic                                       rd_valid_s;
  logic                                       rd_dirty_s;
  logic                                       lookup_s;
  logic                                       hit_s;
  logic                                       store_hit_s;
  logic                                       fill_done_s;
  logic                                       wb_done_s;

  dcache_tag_sram u_tag_sram (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_index (cpu_index_s),
    .rd_tag   (rd_tag_s),
    .rd_valid (rd_valid_s),
    .rd_dirty (rd_dirty_s),
    .wr_en    (sram_we),
    .wr_index (cpu_index_s),
    .wr_tag   (cpu_tag_s),
    .wr_dirty (store_hit_s)
  );

  // Address split and lookup/transfer qualifiers.
  always_comb begin
    cpu_tag_s    = cpu_addr[DRAM_ADDRESS_SIZE-1 -: DCACHE_TAG];
    cpu_index_s  = cpu_addr[DCACHE_OFFSET +: DCACHE_INDEX];
    cpu_offset_s = cpu_addr[DCACHE_OFFSET-1:0];
    cpu_block_s  = cpu_addr[DRAM_ADDRESS_SIZE-1:DCACHE_OFFSET];
    lookup_s     = (state_r == COMPARE) && cpu_req;
    hit_s        = lookup_s && rd_valid_s && (rd_tag_s == cpu_tag_s);
    store_hit_s  = hit_s && cpu_we;
    // mem_req_r gating ignores a stray mem_ready during the inter-transfer gap
    fill_done_s  = (state_r == ALLOCATE) && mem_req_r && mem_ready;
    wb_done_s    = (state_r == WRITEBACK) && mem_req_r && mem_ready;
  end

  // Data SRAM write path and load data.
  always_comb begin
    sram_we = store_hit_s || fill_done_s;
    if (fill_done_s) begin
      sram_wdata = mem_rdata;
    end else if (store_hit_s) begin
      sram_wdata = merge_word(sram_rdata, cpu_offset_s, cpu_wdata);
    end else begin
      sram_wdata = '0;
    end
    if (hit_s && !cpu_we) begin
      cpu_rdata = sram_rdata[cpu_offset_s];
    end else begin
      cpu_rdata = '0;
    end
  end

  assign cpu_ready  = hit_s;
  assign sram_index = cpu_index_s;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_we_r ? sram_rdata : '0;
  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
  assign wb_count   = wb_cnt_r;

  // Controller FSM with registered DRAM handshake and statistics.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= COMPARE;
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= '0;
      refill_r   <= 1'b0;
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
      wb_cnt_r   <= 32'd0;
    end else begin
      case (state_r)
        COMPARE: begin
          if (lookup_s) begin
            // refill_r marks the post-fill re-evaluation, which is not counted
            refill_r <= 1'b0;
            if (hit_s) begin
              if (!refill_r) begin
                hit_cnt_r <= sat_inc(hit_cnt_r);
              end
            end else begin
              if (!refill_r) begin
                miss_cnt_r <= sat_inc(miss_cnt_r);
              end
              mem_req_r <= 1'b1;
              if (rd_valid_s && rd_dirty_s) begin
                state_r    <= WRITEBACK;
                mem_we_r   <= 1'b1;
                mem_addr_r <= {rd_tag_s, cpu_index_s};
              end else begin
                state_r    <= ALLOCATE;
                mem_we_r   <= 1'b0;
                mem_addr_r <= cpu_block_s;
              end
            end
          end
        end
        WRITEBACK: begin
          if (wb_done_s) begin
            // drop mem_req for one cycle before the fill request
            wb_cnt_r   <= sat_inc(wb_cnt_r);
            state_r    <= ALLOCATE;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= cpu_block_s;
          end
        end
        ALLOCATE: begin
          if (fill_done_s) begin
            state_r   <= COMPARE;
            mem_req_r <= 1'b0;
            refill_r  <= 1'b1;
          end else if (!mem_req_r) begin
            mem_req_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= COMPARE;
          mem_req_r <= 1'b0;
          mem_we_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller (BLOCK=4, INDEX=3).
module tb_dcache_controller;
  import dcache_controller_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        sram_we;
  logic [2:0]  sram_index;
  line_t       sram_wdata;
  line_t       sram_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  line_t       mem_wdata;
  line_t       mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] wb_count;

  int checks;
  int errors;

  line_t sram_mem [8];

  dcache_controller dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .sram_we    (sram_we),
    .sram_index (sram_index),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data SRAM model: combinational read, write at the rising edge.
  always @(posedge clock) begin
    if (sram_we) sram_mem[sram_index] <= sram_wdata;
  end
  assign sram_rdata = sram_mem[sram_index];

  function automatic line_t mk_line(input logic [31:0] w0, input logic [31:0] w1,
                                    input logic [31:0] w2, input logic [31:0] w3);
    line_t l;
    l[0] = w0;
    l[1] = w1;
    l[2] = w2;
    l[3] = w3;
    return l;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 12'h040;
    cpu_wdata = 32'd0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) sram_mem[i] = '0;

    // Reset with a request pending
    tick();
    tick();
    check("rst_cpu_ready", 128'(cpu_ready), 128'd0);
    check("rst_sram_we", 128'(sram_we), 128'd0);
    check("rst_mem_req", 128'(mem_req), 128'd0);
    check("rst_mem_we", 128'(mem_we), 128'd0);
    check("rst_cpu_rdata", 128'(cpu_rdata), 128'd0);
    check("rst_counters", 128'({hit_count, miss_count, wb_count}), 128'd0);
    reset_n = 1'b1;
    #1;

    // Cold load 0x040 -> miss, fill {1,2,3,4}
    check("miss_no_ready", 128'(cpu_ready), 128'd0);
    tick();
    check("alloc_mem_req", 128'(mem_req), 128'd1);
    check("alloc_mem_we", 128'(mem_we), 128'd0);
    check("alloc_mem_addr", 128'(mem_addr), 128'h010);
    check("alloc_miss_cnt", 128'(miss_count), 128'd1);
    mem_rdata = mk_line(32'd1, 32'd2, 32'd3, 32'd4);
    mem_ready = 1'b1;
    #1;
    check("fill_sram_we", 128'(sram_we), 128'd1);
    check("fill_sram_wdata", 128'(sram_wdata), 128'(mk_line(32'd1, 32'd2, 32'd3, 32'd4)));
    check("fill_cpu_ready", 128'(cpu_ready), 128'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    check("refill_ready", 128'(cpu_ready), 128'd1);
    check("refill_rdata", 128'(cpu_rdata), 128'd1);
    check("refill_mem_req", 128'(mem_req), 128'd0);
    tick();
    check("refill_hit_cnt", 128'(hit_count), 128'd0);
    check("refill_miss_cnt", 128'(miss_count), 128'd1);

    // Load hit 0x042
    cpu_addr = 12'h042;
    #1;
    check("hit_ready", 128'(cpu_ready), 128'd1);
    check("hit_rdata", 128'(cpu_rdata), 128'd3);
    tick();
    check("hit_cnt_1", 128'(hit_count), 128'd1);

    // Store hit 0xAA to 0x041
    cpu_we    = 1'b1;
    cpu_addr  = 12'h041;
    cpu_wdata = 32'h0000_00AA;
    #1;
    check("st_ready", 128'(cpu_ready), 128'd1);
    check("st_sram_we", 128'(sram_we), 128'd1);
    check("st_sram_wdata", 128'(sram_wdata), 128'(mk_line(32'd1, 32'hAA, 32'd3, 32'd4)));
    check("st_mem_req", 128'(mem_req), 128'd0);
    tick();
    check("st_dirty0", 128'(dut.u_tag_sram.dirty_r[0]), 128'd1);
    check("st_hit_cnt", 128'(hit_count), 128'd2);

    // Conflict load 0x240 on dirty index 0 -> write-back then fill
    cpu_we   = 1'b0;
    cpu_addr = 12'h240;
    #1;
    check("conf_no_ready", 128'(cpu_ready), 128'd0);
    check("conf_no_sram_we", 128'(sram_we), 128'd0);
    tick();
    check("wb_mem_req", 128'(mem_req), 128'd1);
    check("wb_mem_we", 128'(mem_we), 128'd1);
    check("wb_mem_addr", 128'(mem_addr), 128'h010);
    check("wb_mem_wdata", 128'(mem_wdata), 128'(mk_line(32'd1, 32'hAA, 32'd3, 32'd4)));
    check("wb_miss_cnt", 128'(miss_count), 128'd2);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    check("wb_cnt", 128'(wb_count), 128'd1);
    check("gap_mem_req", 128'(mem_req), 128'd0);
    check("gap_mem_we", 128'(mem_we), 128'd0);
    tick();

    // Fill held off for 5 cycles
    for (int i = 0; i < 5; i++) begin
      check("wait_mem_req", 128'(mem_req), 128'd1);
      check("wait_mem_we", 128'(mem_we), 128'd0);
      check("wait_mem_addr", 128'(mem_addr), 128'h090);
      check("wait_cpu_ready", 128'(cpu_ready), 128'd0);
      check("wait_sram_we", 128'(sram_we), 128'd0);
      tick();
    end

    // Reset pulse in ALLOCATE
    reset_n = 1'b0;
    #1;
    check("rstp_mem_req", 128'(mem_req), 128'd0);
    check("rstp_sram_we", 128'(sram_we), 128'd0);
    check("rstp_counters", 128'({hit_count, miss_count, wb_count}), 128'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("rstp_sram_kept", 128'(sram_mem[0]), 128'(mk_line(32'd1, 32'hAA, 32'd3, 32'd4)));
    check("rstp_miss_ready", 128'(cpu_ready), 128'd0);
    tick();
    check("rstp_alloc_req", 128'(mem_req), 128'd1);
    check("rstp_alloc_addr", 128'(mem_addr), 128'h090);
    check("rstp_miss_cnt", 128'(miss_count), 128'd1);
    mem_rdata = mk_line(32'd5, 32'd6, 32'd7, 32'd8);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    check("rstp_refill_ready", 128'(cpu_ready), 128'd1);
    check("rstp_refill_rdata", 128'(cpu_rdata), 128'd5);
    check("rstp_wb_cnt", 128'(wb_count), 128'd0);

    cpu_req = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
